// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared state encoding and ratio constants for the clock-enable divider
package freq_div_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;
    localparam int MIN_DIV     = 2;
    localparam int DEF_DIV_VAL = 3;
endpackage

// File: rtl/div_counter.sv
// div_counter: modulo-N counter with terminal-count detect and registered duty/tick decode
module div_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_run,
    input  logic         i_clr,
    input  logic [W-1:0] i_ratio,
    input  logic [W-1:0] i_ratio_nxt,
    output logic [W-1:0] o_cnt,
    output logic         o_tc,
    output logic         o_div_out,
    output logic         o_tick
);
    logic [W-1:0] r_cnt;
    logic         r_div_out;
    logic         r_tick;
    logic [W-1:0] w_cnt_n;
    assign o_tc    = r_cnt == i_ratio - W'(1);
    assign w_cnt_n = (!i_run || i_clr || o_tc) ? '0 : r_cnt + W'(1);
    // decode uses next count and next ratio so outputs line up with the count they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_n;
            r_div_out <= i_run && (w_cnt_n < (i_ratio_nxt >> 1));
            r_tick    <= i_run && (w_cnt_n == i_ratio_nxt - W'(1));
        end
    end
    assign o_cnt     = r_cnt;
    assign o_div_out = r_div_out;
    assign o_tick    = r_tick;
endmodule

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: divider control FSM, ratio handshake, pending ratio and clamp;
// new ratios are applied only at a period boundary (or when the divider stops).
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int W       = 4,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         div_out,
    output logic         tick,
    output logic [W-1:0] cnt,
    output logic         active
);
    localparam logic [W-1:0] L_MIN = W'(MIN_DIV);
    state_t       r_state, w_state_n;
    logic [W-1:0] r_ratio, w_ratio_n;
    logic [W-1:0] r_pending, w_pending_n;
    logic         r_err, r_ready, r_active;
    logic         w_hs, w_clamp, w_tc;
    logic [W-1:0] w_cdiv;
    assign w_hs    = cfg_valid && r_ready;
    assign w_clamp = cfg_div < L_MIN;
    assign w_cdiv  = w_clamp ? L_MIN : cfg_div;
    always_comb begin
        w_state_n   = r_state;
        w_ratio_n   = r_ratio;
        w_pending_n = r_pending;
        case (r_state)
            IDLE: begin
                if (w_hs) w_ratio_n = w_cdiv;
                if (en) w_state_n = RUN;
            end
            RUN: begin
                if (!en) begin
                    w_state_n = IDLE;
                end else if (w_hs) begin
                    w_pending_n = w_cdiv;
                    w_state_n   = PEND;
                end
            end
            PEND: begin
                if (!en || w_tc) begin
                    w_ratio_n = r_pending;
                    w_state_n = en ? RUN : IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ratio   <= W'(DEF_DIV);
            r_pending <= '0;
            r_err     <= 1'b0;
            r_ready   <= 1'b1;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ratio   <= w_ratio_n;
            r_pending <= w_pending_n;
            r_err     <= w_hs && w_clamp;
            r_ready   <= w_state_n != PEND;
            r_active  <= w_state_n != IDLE;
        end
    end
    div_counter #(.W(W)) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_run       (w_state_n != IDLE),
        .i_clr       (r_state == IDLE),
        .i_ratio     (r_ratio),
        .i_ratio_nxt (w_ratio_n),
        .o_cnt       (cnt),
        .o_tc        (w_tc),
        .o_div_out   (div_out),
        .o_tick      (tick)
    );
    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign active    = r_active;
endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed bench; outputs packed as {active,ready,err,tick,div_out,cnt}
module tb_freq_div_ctrl;
    logic       clk = 1'b0;
    logic       rst, en, cfg_valid;
    logic [3:0] cfg_div;
    logic       cfg_ready, cfg_err, div_out, tick, active;
    logic [3:0] cnt;
    int         checks = 0;
    int         failures = 0;
    freq_div_ctrl #(.W(4), .DEF_DIV(3)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_out(div_out), .tick(tick),
        .cnt(cnt), .active(active)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [8:0] pk(input logic a, r, e, t, d, input logic [3:0] c);
        return {a, r, e, t, d, c};
    endfunction
    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {active, cfg_ready, cfg_err, tick, div_out, cnt};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed a/r/e/t/d/cnt=%b required=%b", tag, obs, exp);
        end
    endtask
    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 4'd0;
        step();
        chk("reset", pk(0, 1, 0, 0, 0, 0));
        rst = 1'b0; en = 1'b1;
        step(); chk("n3_c0", pk(1, 1, 0, 0, 1, 0));
        step(); chk("n3_c1", pk(1, 1, 0, 0, 0, 1));
        step(); chk("n3_c2", pk(1, 1, 0, 1, 0, 2));
        step(); chk("n3_wrap", pk(1, 1, 0, 0, 1, 0));
        cfg_valid = 1'b1; cfg_div = 4'd6;
        step(); chk("pend6_c1", pk(1, 0, 0, 0, 0, 1));
        cfg_valid = 1'b0;
        step(); chk("pend6_c2", pk(1, 0, 0, 1, 0, 2));
        step(); chk("n6_c0", pk(1, 1, 0, 0, 1, 0));
        step(); step(); chk("n6_c2", pk(1, 1, 0, 0, 1, 2));
        step(); chk("n6_c3", pk(1, 1, 0, 0, 0, 3));
        step(); step(); chk("n6_c5", pk(1, 1, 0, 1, 0, 5));
        step(); chk("n6_wrap", pk(1, 1, 0, 0, 1, 0));
        en = 1'b0;
        step(); chk("idle", pk(0, 1, 0, 0, 0, 0));
        cfg_valid = 1'b1; cfg_div = 4'd1;
        step(); chk("clamp_err", pk(0, 1, 1, 0, 0, 0));
        cfg_valid = 1'b0; en = 1'b1;
        step(); chk("n2_c0", pk(1, 1, 0, 0, 1, 0));
        step(); chk("n2_c1", pk(1, 1, 0, 1, 0, 1));
        step(); chk("n2_wrap", pk(1, 1, 0, 0, 1, 0));
        cfg_valid = 1'b1; cfg_div = 4'd5;
        step(); chk("pend5", pk(1, 0, 0, 1, 0, 1));
        cfg_valid = 1'b0;
        step(); chk("n5_c0", pk(1, 1, 0, 0, 1, 0));
        cfg_valid = 1'b1; cfg_div = 4'd7;
        step(); chk("pend7_c1", pk(1, 0, 0, 0, 1, 1));
        cfg_valid = 1'b0;
        step(); chk("pend7_c2", pk(1, 0, 0, 0, 0, 2));
        en = 1'b0;
        step(); chk("drop_en_pend", pk(0, 1, 0, 0, 0, 0));
        en = 1'b1;
        step(); chk("n7_c0", pk(1, 1, 0, 0, 1, 0));
        step(); step(); chk("n7_c2", pk(1, 1, 0, 0, 1, 2));
        step(); chk("n7_c3", pk(1, 1, 0, 0, 0, 3));
        step(); step(); step(); chk("n7_c6", pk(1, 1, 0, 1, 0, 6));
        step(); chk("n7_wrap", pk(1, 1, 0, 0, 1, 0));
        cfg_valid = 1'b1; cfg_div = 4'd9;
        step(); chk("pend9", pk(1, 0, 0, 0, 1, 1));
        cfg_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("n9_c0", pk(1, 1, 0, 0, 1, 0));
        cfg_valid = 1'b1; cfg_div = 4'd5;
        step(); chk("n9_pend5_c1", pk(1, 0, 0, 0, 1, 1));
        cfg_valid = 1'b0;
        step(); step(); step(); chk("n9_c4", pk(1, 0, 0, 0, 0, 4));
        rst = 1'b1;
        step(); chk("mid_reset", pk(0, 1, 0, 0, 0, 0));
        rst = 1'b0;
        step(); chk("post_rst_c0", pk(1, 1, 0, 0, 1, 0));
        step(); step(); chk("post_rst_n3_tick", pk(1, 1, 0, 1, 0, 2));
        step(); chk("post_rst_wrap", pk(1, 1, 0, 0, 1, 0));
        en = 1'b0;
        step(); chk("idle2", pk(0, 1, 0, 0, 0, 0));
        en = 1'b1; cfg_valid = 1'b1; cfg_div = 4'd4;
        step(); chk("n4_c0", pk(1, 1, 0, 0, 1, 0));
        cfg_valid = 1'b0;
        step(); chk("n4_c1", pk(1, 1, 0, 0, 1, 1));
        step(); chk("n4_c2", pk(1, 1, 0, 0, 0, 2));
        step(); chk("n4_c3", pk(1, 1, 0, 1, 0, 3));
        step(); chk("n4_wrap", pk(1, 1, 0, 0, 1, 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
